// File: rtl/feature_window_buffer.sv
// feature_window_buffer: shifts LANES feature words per accepted beat into a
// DEPTH-word window and presents the whole window (index 0 = newest) to the
// NN input layer with ready/valid handshakes on both sides.
// MODE 0 = BLOCK (non-overlapping windows), MODE 1 = SLIDING (one window per
// beat once full).
// Optional macro FWB_FLUSH_EN adds a 'flush' input that releases a partial,
// zero-padded window early.
module feature_window_buffer #(
  parameter int DATA_W = 16,
  parameter int LANES  = 2,
  parameter int DEPTH  = 26,
  parameter int MODE   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
`ifdef FWB_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*DATA_W-1:0]      in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DEPTH*DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] LANES_F = FW'(LANES);
  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);

  // A zero lane count or a depth that is not a whole number of beats would
  // leave a ragged window, so refuse to elaborate.
  if (LANES < 1 || (DEPTH % LANES) != 0) begin : g_bad_cfg
    $error("feature_window_buffer: LANES must be >= 1 and divide DEPTH");
  end

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // State entered once the window is complete.
  localparam state_t FULL_ST = (MODE != 0) ? ST_STREAM : ST_HOLD;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   win_q [DEPTH];
  logic [DATA_W-1:0]   win_d [DEPTH];
  logic [DATA_W-1:0]   win_shift [DEPTH];
  logic [FW-1:0]       fill_q, fill_d;
  logic [FW-1:0]       fill_push;
  logic                out_valid_q, out_valid_d;
  logic                ready_int;
  logic                push;

  // Window as it would look after one push: new lanes at the low indices,
  // everything else moves up by LANES and the oldest beat falls off the top.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_win
    if (gi < LANES) begin : g_load
      assign win_shift[gi] = in_data[gi*DATA_W +: DATA_W];
    end else begin : g_shift
      assign win_shift[gi] = win_q[gi-LANES];
    end
    assign out_data[gi*DATA_W +: DATA_W] = win_q[gi];
  end

  // Upstream ready: always in FILL, never in HOLD, and in STREAM only when the
  // current window is absent or being consumed this cycle.
  always_comb begin
    ready_int = 1'b0;
    case (state_q)
      ST_FILL:   ready_int = 1'b1;
      ST_HOLD:   ready_int = 1'b0;
      ST_STREAM: ready_int = !out_valid_q || out_ready;
      default:   ready_int = 1'b0;
    endcase
  end

  // Outputs go low together with the registers while reset is held.
  assign in_ready   = rst & ready_int;
  assign push       = in_valid && ready_int;
  assign out_valid  = out_valid_q;
  assign fill_level = fill_q;

  // Next-state logic: clear beats everything, then per-state push/pop rules.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    win_d       = win_q;
    fill_push   = fill_q;
    if (clear) begin
      state_d     = ST_FILL;
      fill_d      = '0;
      out_valid_d = 1'b0;
      for (int i = 0; i < DEPTH; i++) win_d[i] = '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (push) begin
            win_d     = win_shift;
            fill_push = fill_q + LANES_F;
          end
          if (fill_push >= DEPTH_F) begin
            fill_d      = DEPTH_F;
            state_d     = FULL_ST;
            out_valid_d = 1'b1;
          end
`ifdef FWB_FLUSH_EN
          // Flush sees the fill level after this cycle's push; an empty
          // window is never released.
          else if (flush && (fill_push != '0)) begin
            fill_d      = DEPTH_F;
            state_d     = FULL_ST;
            out_valid_d = 1'b1;
          end
`endif
          else begin
            fill_d = fill_push;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_d     = ST_FILL;
            fill_d      = '0;
            out_valid_d = 1'b0;
            for (int i = 0; i < DEPTH; i++) win_d[i] = '0;
          end
        end
        ST_STREAM: begin
          fill_d = DEPTH_F;
          if (push) begin
            win_d       = win_shift;
            out_valid_d = 1'b1;
          end else if (out_ready) begin
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = ST_FILL;
          fill_d      = '0;
          out_valid_d = 1'b0;
          for (int i = 0; i < DEPTH; i++) win_d[i] = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset to an empty window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FILL;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      win_q       <= win_d;
    end
  end

endmodule

// File: tb/tb_feature_window_buffer.sv
// Self-checking bench for feature_window_buffer: one BLOCK-mode and one
// SLIDING-mode instance with default LANES=2, DEPTH=26.
module tb_feature_window_buffer;
  localparam int DW = 16;
  localparam int LN = 2;
  localparam int DP = 26;
  localparam int FW = $clog2(DP + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic               clear0, in_valid0, out_ready0, in_ready0, out_valid0;
  logic [LN*DW-1:0]   in_data0;
  logic [DP*DW-1:0]   out_data0;
  logic [FW-1:0]      fill0;
  logic               clear1, in_valid1, out_ready1, in_ready1, out_valid1;
  logic [LN*DW-1:0]   in_data1;
  logic [DP*DW-1:0]   out_data1;
  logic [FW-1:0]      fill1;
`ifdef FWB_FLUSH_EN
  logic               flush0, flush1;
`endif

  feature_window_buffer #(.DATA_W(DW), .LANES(LN), .DEPTH(DP), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .clear(clear0),
`ifdef FWB_FLUSH_EN
    .flush(flush0),
`endif
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .fill_level(fill0)
  );

  feature_window_buffer #(.DATA_W(DW), .LANES(LN), .DEPTH(DP), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear1),
`ifdef FWB_FLUSH_EN
    .flush(flush1),
`endif
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .fill_level(fill1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] w(input logic [DP*DW-1:0] d, input int i);
    return d[i*DW +: DW];
  endfunction

  typedef struct {
    logic        in_valid;
    logic [15:0] l0, l1;
    logic        out_ready;
    logic        clr;
    logic        e_rdy;
    logic        e_ov;
    int          e_fill;
    logic [15:0] e_w0, e_w1, e_w25;
  } vec_t;

  function automatic vec_t mk(input logic iv, input int l0, input int l1, input logic ordy,
                              input logic clr, input logic erdy, input logic eov, input int efill,
                              input int ew0, input int ew1, input int ew25);
    vec_t v;
    v.in_valid = iv; v.l0 = 16'(l0); v.l1 = 16'(l1); v.out_ready = ordy; v.clr = clr;
    v.e_rdy = erdy; v.e_ov = eov; v.e_fill = efill;
    v.e_w0 = 16'(ew0); v.e_w1 = 16'(ew1); v.e_w25 = 16'(ew25);
    return v;
  endfunction

  vec_t tbl [21];
  int   windows;
  logic [15:0] prev_w0;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected run to complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table for the BLOCK instance: fill, hold, release, refill, clear.
    for (int n = 0; n < 13; n++)
      tbl[n] = mk(1, 2*n, 2*n+1, 0, 0, (n < 12), (n == 12), 2*n+2, 2*n, 2*n+1, (n == 12) ? 1 : 0);
    tbl[13] = mk(1, 90, 91, 0, 0, 0, 1, 26, 24, 25, 1);
    tbl[14] = mk(1, 92, 93, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      tbl[15+k] = mk(1, 100+2*k, 101+2*k, 0, 0, 1, 0, 2*k+2, 100+2*k, 101+2*k, 0);
    tbl[20] = mk(1, 7, 8, 0, 1, 1, 0, 0, 0, 0, 0);

    rst = 1'b0;
    clear0 = 0; in_valid0 = 0; out_ready0 = 0; in_data0 = '0;
    clear1 = 0; in_valid1 = 0; out_ready1 = 0; in_data1 = '0;
`ifdef FWB_FLUSH_EN
    flush0 = 0; flush1 = 0;
`endif
    #1;
    check("rst_out_valid", {31'd0, out_valid0}, 0);
    check("rst_fill", {27'd0, fill0}, 0);
    check("rst_in_ready", {31'd0, in_ready0}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready0}, 1);
    check("post_rst_zero_window", {31'd0, (out_data0 == '0)}, 1);
    check("post_rst_fill1", {27'd0, fill1}, 0);

    // Table-driven run on the BLOCK instance.
    for (int i = 0; i < 21; i++) begin
      in_valid0 = tbl[i].in_valid; in_data0 = {tbl[i].l1, tbl[i].l0};
      out_ready0 = tbl[i].out_ready; clear0 = tbl[i].clr;
      @(posedge clk); #1;
      $display("vec %0d: fill=%0d ov=%0d rdy=%0d w0=%0d", i, fill0, out_valid0, in_ready0, w(out_data0, 0));
      check($sformatf("v%0d_in_ready", i), {31'd0, in_ready0}, {31'd0, tbl[i].e_rdy});
      check($sformatf("v%0d_out_valid", i), {31'd0, out_valid0}, {31'd0, tbl[i].e_ov});
      check($sformatf("v%0d_fill", i), {27'd0, fill0}, tbl[i].e_fill);
      check($sformatf("v%0d_w0", i), {16'd0, w(out_data0, 0)}, {16'd0, tbl[i].e_w0});
      check($sformatf("v%0d_w1", i), {16'd0, w(out_data0, 1)}, {16'd0, tbl[i].e_w1});
      check($sformatf("v%0d_w25", i), {16'd0, w(out_data0, 25)}, {16'd0, tbl[i].e_w25});
      if (i == 14) check("release_all_zero", {31'd0, (out_data0 == '0)}, 1);
    end
    clear0 = 0; in_valid0 = 0;
    check("clear_all_zero", {31'd0, (out_data0 == '0)}, 1);

    // SLIDING: fill with out_ready low.
    for (int n = 0; n < 13; n++) begin
      in_valid1 = 1; in_data1 = {16'(2*n+1), 16'(2*n)}; out_ready1 = 0;
      @(posedge clk); #1;
    end
    check("s_full_out_valid", {31'd0, out_valid1}, 1);
    check("s_full_in_ready", {31'd0, in_ready1}, 0);
    check("s_full_fill", {27'd0, fill1}, 26);
    check("s_full_w0", {16'd0, w(out_data1, 0)}, 24);

    // SLIDING: out_ready held, 4 back-to-back pushes, then drain.
    windows = 0; prev_w0 = '0;
    for (int k = 0; k < 5; k++) begin
      out_ready1 = 1; in_valid1 = (k < 4);
      in_data1 = {16'(27+2*k), 16'(26+2*k)};
      #1;
      check($sformatf("s_stream%0d_in_ready", k), {31'd0, in_ready1}, 1);
      if (out_valid1) begin
        windows++;
        $display("window %0d: w0=%0d w2=%0d", windows, w(out_data1, 0), w(out_data1, 2));
        check($sformatf("s_win%0d_w0", k), {16'd0, w(out_data1, 0)}, 24 + 2*k);
        if (k > 0) check($sformatf("s_win%0d_shift", k), {16'd0, w(out_data1, 2)}, {16'd0, prev_w0});
        prev_w0 = w(out_data1, 0);
      end
      @(posedge clk); #1;
    end
    check("s_window_count", windows, 5);
    check("s_drained_out_valid", {31'd0, out_valid1}, 0);
    check("s_drained_fill", {27'd0, fill1}, 26);

    // SLIDING backpressure.
    in_valid1 = 1; in_data1 = {16'd51, 16'd50}; out_ready1 = 0;
    @(posedge clk); #1;
    check("bp_first_out_valid", {31'd0, out_valid1}, 1);
    check("bp_first_w0", {16'd0, w(out_data1, 0)}, 50);
    for (int c = 0; c < 5; c++) begin
      in_valid1 = 1; in_data1 = {16'd61, 16'd60}; out_ready1 = 0;
      #1;
      check($sformatf("bp%0d_in_ready", c), {31'd0, in_ready1}, 0);
      @(posedge clk); #1;
      check($sformatf("bp%0d_w0", c), {16'd0, w(out_data1, 0)}, 50);
      check($sformatf("bp%0d_w1", c), {16'd0, w(out_data1, 1)}, 51);
    end
    for (int k = 0; k < 3; k++) begin
      in_valid1 = 1; in_data1 = {16'(71+2*k), 16'(70+2*k)}; out_ready1 = 1;
      #1;
      check($sformatf("rel%0d_in_ready", k), {31'd0, in_ready1}, 1);
      @(posedge clk); #1;
      check($sformatf("rel%0d_w0", k), {16'd0, w(out_data1, 0)}, 70 + 2*k);
      check($sformatf("rel%0d_out_valid", k), {31'd0, out_valid1}, 1);
    end
    in_valid1 = 0; out_ready1 = 1;
    @(posedge clk); #1;
    check("rel_drain_out_valid", {31'd0, out_valid1}, 0);
    out_ready1 = 0;

    // Asynchronous reset in the middle of HOLD.
    for (int n = 0; n < 13; n++) begin
      in_valid0 = 1; in_data0 = {16'(2*n+1), 16'(2*n)}; out_ready0 = 0;
      @(posedge clk); #1;
    end
    in_valid0 = 0;
    @(posedge clk); #1;
    check("hold_out_valid", {31'd0, out_valid0}, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid0}, 0);
    check("arst_fill", {27'd0, fill0}, 0);
    check("arst_window", {31'd0, (out_data0 == '0)}, 1);
    check("arst_in_ready", {31'd0, in_ready0}, 0);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1; in_data0 = {16'd4, 16'd3};
    @(posedge clk); #1;
    in_valid0 = 0;
    check("resume_fill", {27'd0, fill0}, 2);
    check("resume_w0", {16'd0, w(out_data0, 0)}, 3);
    check("resume_out_valid", {31'd0, out_valid0}, 0);

`ifdef FWB_FLUSH_EN
    clear0 = 1;
    @(posedge clk); #1;
    clear0 = 0;
    for (int n = 0; n < 3; n++) begin
      in_valid0 = 1; in_data0 = {16'(2*n+2), 16'(2*n+1)};
      @(posedge clk); #1;
    end
    in_valid0 = 0; flush0 = 1;
    @(posedge clk); #1;
    flush0 = 0;
    check("flush_out_valid", {31'd0, out_valid0}, 1);
    check("flush_fill", {27'd0, fill0}, 26);
    begin
      int exp6 [6];
      exp6 = '{5, 6, 3, 4, 1, 2};
      for (int i = 0; i < DP; i++)
        check($sformatf("flush_w%0d", i), {16'd0, w(out_data0, i)}, (i < 6) ? exp6[i] : 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/feature_window_buffer.md
Name: feature_window_buffer

Overview:
- Parametrised successor to the two-lane feature FIFO in the audio-processing path.
- Accepts LANES feature words per beat, shifts them into a DEPTH-entry window, and presents the whole window to the NN input layer.
- Adds a fill counter, ready/valid handshakes on both sides, block and sliding window modes, and a synchronous clear.

Parameters:
- DATA_W, 16, width of one feature word.
- LANES, 2, words accepted per input beat. Must be ≥1 and divide DEPTH; otherwise elaboration error.
- DEPTH, 26, window length in words (NN array width).
- MODE, 0, 0 = BLOCK (non-overlapping windows), 1 = SLIDING (new window every beat once full).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear, one-cycle pulse.
- in_valid  in  1  input beat valid.
- in_ready  out  1  buffer can accept a beat.
- in_data  in  LANES x DATA_W  lane k = k-th word of the beat.
- out_valid  out  1  complete window presented.
- out_ready  in  1  consumer accepts the window.
- out_data  out  DEPTH x DATA_W  window; index 0 = newest.
- fill_level  out  $clog2(DEPTH+1)  words currently held (0..DEPTH).

Behaviour:
- Reset (rst=0, asynchronous): all window entries 0, fill_level 0, out_valid 0, state FILL. in_ready is 1 after reset release.
- A push occurs on a clk edge with in_valid && in_ready.
- On push:
  - win[k] <= in_data[k] for k < LANES.
  - win[i] <= win[i-LANES] for LANES ≤ i < DEPTH.
  - The oldest LANES words are discarded.
- out_data is the window register itself; no extra latency.
- Priority: rst > clear > push/pop. clear zeroes the window, sets fill_level 0, out_valid 0, state FILL. A push on the clear cycle is dropped.
- fill_level saturates at DEPTH and never wraps.
- State FILL:
  - in_ready=1, out_valid=0.
  - Each push adds LANES to fill_level.
  - The push that makes fill_level == DEPTH moves to HOLD (MODE 0) or STREAM (MODE 1). out_valid=1 from the next cycle.
- State HOLD (MODE 0):
  - in_ready=0, out_valid=1, out_data stable.
  - On out_ready: window zeroed, fill_level 0, out_valid 0 next cycle, state FILL.
  - in_valid during HOLD is ignored (stalled upstream).
- State STREAM (MODE 1):
  - fill_level stays DEPTH.
  - in_ready = !out_valid || out_ready.
  - out_valid set by a push, cleared by out_ready without a push.
  - Simultaneous out_ready and push: current window consumed, shifted window valid next cycle, out_valid stays 1.
  - out_valid held with out_ready=0: window must not change.
- Every window is delivered exactly once; no window is skipped or duplicated.
- Unfilled entries (indices ≥ fill_level) are always 0.

Optional Feature:
- Macro: FWB_FLUSH_EN.
- Defined: adds input port flush (1 bit).
  - In FILL with fill_level > 0, flush sets fill_level to DEPTH and enters HOLD/STREAM. out_valid=1 next cycle with the partial window zero-padded at the high indices.
  - flush with fill_level 0 is ignored. flush in HOLD/STREAM is ignored.
  - flush and a push in the same cycle: the push is applied first, then the flush.
- Not defined: no flush port. A partial window is only ever discarded by clear or rst.

Test Plan:
1. MODE0, LANES2, DEPTH26: 13 beats with in_data={2n,2n+1}, n=0..12, out_ready=0.
   - out_valid rises the cycle after beat 12.
   - out_data[0]=24, out_data[1]=25, out_data[25]=1.
   - in_ready=0. Then out_ready=1 for 1 cycle → fill_level 0, all entries 0.
2. MODE1: fill the window, then hold out_ready=1 and push 4 more beats back-to-back.
   - Exactly 5 windows accepted.
   - Each window is shifted by 2 words versus the previous one.
   - in_ready stays 1.
3. MODE1 backpressure: out_ready=0 for 5 cycles with in_valid=1.
   - in_ready=0 and out_data unchanged for those cycles.
   - Releasing out_ready gives one push per cycle.
4. clear asserted with in_valid=1 at fill_level 10.
   - Next cycle fill_level 0, window zero, out_valid 0.
   - The pushed data is absent.
5. Assert rst=0 asynchronously mid-HOLD, between clock edges.
   - out_valid and all outputs drop to 0 immediately, before the next edge.
   - Normal filling resumes after release.
6. FWB_FLUSH_EN, MODE0: 3 beats {1,2},{3,4},{5,6}, then flush.
   - Next cycle out_valid=1, out_data[0..5]=5,6,3,4,1,2, entries 6..25 = 0.
   - fill_level=26.
